// File: rtl/seq_alu_core.sv
// seq_alu_core: multi-cycle arithmetic engine. It performs add, sub, a signed
// Booth radix-2 multiply and a non-restoring divide on WIDTH-bit operands.
//
// Optional build macro: SEQ_ALU_SIGNED_DIV_EN
//   - When defined, op 11 is a signed divide.
//   - The quotient truncates toward zero and the remainder takes the sign of a.
//   - This adds one SFIX cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   start      in   request, sampled only in IDLE
//   op         in   00 add, 01 sub, 10 mul, 11 div
//   a, b       in   operands, captured on the accept edge
//   busy       out  high whenever the FSM is not in IDLE
//   done       out  one-cycle completion pulse
//   result_hi  out  product high half / remainder / sign extension
//   result_lo  out  sum, product low half or quotient
//   ovf        out  signed overflow (add/sub only)
//   div_zero   out  divisor was zero (divide only)
module seq_alu_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             ovf,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned AW    = WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_MITER = 3'd3,
        S_DITER = 3'd4,
        S_CORR  = 3'd5,
        S_OUT   = 3'd6
`ifdef SEQ_ALU_SIGNED_DIV_EN
        , S_SFIX = 3'd7
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [AW-1:0]      r_acc;
    logic [WIDTH-1:0]   r_q;
    logic               r_q1;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dz;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_ovf;
    logic               r_dzo;
`ifdef SEQ_ALU_SIGNED_DIV_EN
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
`endif

    logic [AW-1:0]      w_b_sext;
    logic [AW-1:0]      w_b_zext;
    logic [AW-1:0]      w_addsub;
    logic [AW-1:0]      w_m_sum;
    logic [AW-1:0]      w_d_shift;
    logic [AW-1:0]      w_d_sum;
    logic               w_is_div;

    assign busy      = r_busy;
    assign done      = r_done;
    assign result_hi = r_hi;
    assign result_lo = r_lo;
    assign ovf       = r_ovf;
    assign div_zero  = r_dzo;

    assign w_is_div  = (r_op == 2'b11);
    assign w_b_sext  = {r_b[WIDTH-1], r_b};
    assign w_b_zext  = {1'b0, r_b};

    // Add/sub is computed at WIDTH+1 bits, so bit WIDTH is the true sign.
    assign w_addsub  = r_op[0] ? ({r_a[WIDTH-1], r_a} - w_b_sext)
                               : ({r_a[WIDTH-1], r_a} + w_b_sext);

`ifdef SEQ_ALU_SIGNED_DIV_EN
    assign w_a_abs   = r_a[WIDTH-1] ? WIDTH'(-r_a) : r_a;
    assign w_b_abs   = r_b[WIDTH-1] ? WIDTH'(-r_b) : r_b;
`endif

    // Booth recode on {Q0, Q-1}.
    // The accumulator is WIDTH+1 bits wide so that subtracting the most
    // negative b cannot overflow.
    always_comb begin
        w_m_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b10:   w_m_sum = r_acc - w_b_sext;
            2'b01:   w_m_sum = r_acc + w_b_sext;
            default: w_m_sum = r_acc;
        endcase
    end

    // Non-restoring step.
    // Shift first, then add or subtract b chosen by the pre-shift sign.
    assign w_d_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_d_sum   = r_acc[WIDTH] ? (w_d_shift + w_b_zext)
                                    : (w_d_shift - w_b_zext);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD: begin
                if (!r_op[1])         w_next = S_EXEC;
                else if (!r_op[0])    w_next = S_MITER;
                else if (r_b == '0)   w_next = S_OUT;
                else                  w_next = S_DITER;
            end
            S_EXEC:  w_next = S_OUT;
            S_MITER: if (r_cnt == CNT_W'(1)) w_next = S_OUT;
            S_DITER: if (r_cnt == CNT_W'(1)) w_next = S_CORR;
`ifdef SEQ_ALU_SIGNED_DIV_EN
            S_CORR:  w_next = S_SFIX;
            S_SFIX:  w_next = S_OUT;
`else
            S_CORR:  w_next = S_OUT;
`endif
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register with registered busy/done.
    // done is driven from the OUT cycle, so it appears on the edge leaving OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (r_state == S_OUT);
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_ovf   <= 1'b0;
            r_dzo   <= 1'b0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                    end
                end
                S_LOAD: begin
                    r_acc <= '0;
                    r_q   <= r_a;
                    r_q1  <= 1'b0;
                    r_cnt <= CNT_W'(WIDTH);
                    r_dz  <= w_is_div && (r_b == '0);
                    r_hi  <= '0;
                    r_lo  <= '0;
                    r_ovf <= 1'b0;
                    r_dzo <= 1'b0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
                    // Divide runs on magnitudes; the signs are applied in SFIX.
                    if (w_is_div) begin
                        r_q     <= w_a_abs;
                        r_b     <= w_b_abs;
                        r_neg_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                        r_neg_r <= r_a[WIDTH-1];
                    end
`endif
                end
                S_EXEC: r_acc <= w_addsub;
                S_MITER: begin
                    r_acc <= {w_m_sum[AW-1], w_m_sum[AW-1:1]};
                    r_q   <= {w_m_sum[0], r_q[WIDTH-1:1]};
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_DITER: begin
                    r_acc <= w_d_sum;
                    r_q   <= {r_q[WIDTH-2:0], ~w_d_sum[AW-1]};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_CORR: if (r_acc[WIDTH]) r_acc <= r_acc + w_b_zext;
`ifdef SEQ_ALU_SIGNED_DIV_EN
                S_SFIX: begin
                    if (r_neg_q) r_q   <= WIDTH'(-r_q);
                    if (r_neg_r) r_acc <= AW'(-r_acc);
                end
`endif
                S_OUT: begin
                    if (!r_op[1]) begin
                        r_lo  <= r_acc[WIDTH-1:0];
                        r_hi  <= {WIDTH{r_acc[WIDTH]}};
                        r_ovf <= r_acc[WIDTH] ^ r_acc[WIDTH-1];
                    end else if (r_dz) begin
                        r_lo  <= '1;
                        r_hi  <= r_a;
                        r_dzo <= 1'b1;
                    end else begin
                        r_lo  <= r_q;
                        r_hi  <= r_acc[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
